// File: rtl/uart_rx_defs.sv
// Shared UART RX constants: prescale limits, reset configuration, legal ratios.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_rx_defs;

  // Smallest usable oversampling ratio. Three centred samples need at least 4 edges.
  localparam int PRESCALE_MIN   = 4;
  // Configuration the counter wakes up with out of reset.
  localparam int PRESCALE_RST   = 8;
  localparam int FRAME_BITS_RST = 10;

  // Commonly used legal oversampling ratios.
  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

endpackage

// File: rtl/rx_oversample_counter.sv
// Oversampling edge/bit counter for UART RX: centred sample strobes plus bit/frame done pulses.
// Latency: strobes are combinational from the counter registers (zero cycles); config is latched while enable==0.
// Backpressure: none; enable==0 clears the counters. Define RX_TRIPLE_SAMPLE_EN for 3-sample majority strobes plus sample_idx.
module rx_oversample_counter
  import uart_rx_defs::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_stb,
  output logic                  bit_done,
  output logic                  frame_done
`ifdef RX_TRIPLE_SAMPLE_EN
  ,
  output logic [1:0]            sample_idx
`endif
);

  localparam logic [PRESCALE_W-1:0] P_ONE      = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_TWO      = PRESCALE_W'(2);
  localparam logic [PRESCALE_W-1:0] P_MIN      = PRESCALE_W'(PRESCALE_MIN);
  localparam logic [PRESCALE_W-1:0] P_RST      = PRESCALE_W'(PRESCALE_RST);
  localparam logic [BIT_CNT_W-1:0]  B_ONE      = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]  B_MIN      = BIT_CNT_W'(2);
  localparam logic [BIT_CNT_W-1:0]  B_RST      = BIT_CNT_W'(FRAME_BITS_RST);

  // Ratios below the minimum are raised to it; odd ratios are rounded down so the centre is well defined.
  function automatic logic [PRESCALE_W-1:0] sanitise_prescale(input logic [PRESCALE_W-1:0] p);
    logic [PRESCALE_W-1:0] r;
    r    = (p < P_MIN) ? P_MIN : p;
    r[0] = 1'b0;
    return r;
  endfunction

  // A frame needs at least a start and a stop bit.
  function automatic logic [BIT_CNT_W-1:0] sanitise_frame_bits(input logic [BIT_CNT_W-1:0] f);
    return (f < B_MIN) ? B_MIN : f;
  endfunction

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BIT_CNT_W-1:0]  frame_bits_q, frame_bits_d;
  logic [PRESCALE_W-1:0] half;
  logic                  last_edge;
  logic                  last_bit;

  assign half      = prescale_q >> 1;
  assign last_edge = (edge_cnt_q == (prescale_q - P_ONE));
  assign last_bit  = (bit_cnt_q == (frame_bits_q - B_ONE));

  // Next state: reload config and clear while idle, otherwise advance edge then bit with wrap.
  always_comb begin
    prescale_d   = prescale_q;
    frame_bits_d = frame_bits_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    if (!enable) begin
      prescale_d   = sanitise_prescale(prescale);
      frame_bits_d = sanitise_frame_bits(frame_bits);
      edge_cnt_d   = '0;
      bit_cnt_d    = '0;
    end else if (last_edge) begin
      edge_cnt_d = '0;
      bit_cnt_d  = last_bit ? '0 : (bit_cnt_q + B_ONE);
    end else begin
      edge_cnt_d = edge_cnt_q + P_ONE;
    end
  end

  // State registers; reset restores the default 8x / 10-bit configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      prescale_q   <= P_RST;
      frame_bits_q <= B_RST;
    end else begin
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      prescale_q   <= prescale_d;
      frame_bits_q <= frame_bits_d;
    end
  end

  assign edge_cnt   = edge_cnt_q;
  assign bit_cnt    = bit_cnt_q;
  assign bit_done   = enable & last_edge;
  assign frame_done = bit_done & last_bit;

`ifdef RX_TRIPLE_SAMPLE_EN
  // Three consecutive strobes straddling the bit centre, tagged 0/1/2 for the majority voter.
  always_comb begin
    sample_stb = 1'b0;
    sample_idx = 2'd0;
    if (enable) begin
      if (edge_cnt_q == (half - P_TWO)) begin
        sample_stb = 1'b1;
        sample_idx = 2'd0;
      end else if (edge_cnt_q == (half - P_ONE)) begin
        sample_stb = 1'b1;
        sample_idx = 2'd1;
      end else if (edge_cnt_q == half) begin
        sample_stb = 1'b1;
        sample_idx = 2'd2;
      end
    end
  end
`else
  assign sample_stb = enable & (edge_cnt_q == (half - P_ONE));
`endif

endmodule

// File: tb/tb_rx_oversample_counter.sv
// Directed bench for rx_oversample_counter: per-cycle compare against a counting model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a. Builds with or without RX_TRIPLE_SAMPLE_EN.
module tb_rx_oversample_counter;
  import uart_rx_defs::*;

  localparam int PW = 6;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [PW-1:0] prescale;
  logic [BW-1:0] frame_bits;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sample_stb;
  logic          bit_done;
  logic          frame_done;
`ifdef RX_TRIPLE_SAMPLE_EN
  logic [1:0]    sample_idx;
`endif

  int n_vec = 0;
  int n_err = 0;

  rx_oversample_counter #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .prescale   (prescale),
    .frame_bits (frame_bits),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sample_stb (sample_stb),
    .bit_done   (bit_done),
    .frame_done (frame_done)
`ifdef RX_TRIPLE_SAMPLE_EN
    ,
    .sample_idx (sample_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] cur_idx();
`ifdef RX_TRIPLE_SAMPLE_EN
    return sample_idx;
`else
    return 2'd0;
`endif
  endfunction

  // Compares n consecutive cycles against a counter that starts at edge 0, bit 0.
  task automatic run_frame(input string tag, input int p, input int fb, input int n, input int exp_frames);
    int frames;
    frames = 0;
    for (int c = 0; c < n; c++) begin
      int          e, b, h;
      logic        bd, fd, stb;
      logic [1:0]  idx;
      logic [31:0] exp, got;
      e  = c % p;
      b  = (c / p) % fb;
      h  = p / 2;
      bd = (e == p - 1);
      fd = bd && (b == fb - 1);
`ifdef RX_TRIPLE_SAMPLE_EN
      stb = (e >= h - 2) && (e <= h);
      idx = stb ? 2'(e - (h - 2)) : 2'd0;
`else
      stb = (e == h - 1);
      idx = 2'd0;
`endif
      exp = {17'd0, idx, 6'(e), 4'(b), stb, bd, fd};
      got = {17'd0, cur_idx(), edge_cnt, bit_cnt, sample_stb, bit_done, frame_done};
      check_eq($sformatf("%s c%0d", tag, c), got, exp);
      if (frame_done) frames++;
      step();
    end
    check_eq({tag, " frames"}, frames, exp_frames);
  endtask

  task automatic idle_load(input int p, input int fb);
    enable     = 1'b0;
    prescale   = PW'(p);
    frame_bits = BW'(fb);
    step();
    check_eq("idle edge", 32'(edge_cnt), 0);
    check_eq("idle bit", 32'(bit_cnt), 0);
    enable = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    enable     = 1'b0;
    prescale   = PW'(PRESC_8);
    frame_bits = BW'(10);
    step();
    step();
    check_eq("rst edge", 32'(edge_cnt), 0);
    check_eq("rst bit", 32'(bit_cnt), 0);
    check_eq("rst strobes", {29'd0, sample_stb, bit_done, frame_done}, 0);
    rst = 1'b1;

    // 8x, 10-bit frame: one frame_done at cycle 80, then bit_cnt wraps to 0.
    idle_load(PRESC_8, 10);
    run_frame("p8f10", 8, 10, 81, 1);

    // 16x, 11-bit frame: frame_done after 176 cycles.
    idle_load(PRESC_16, 11);
    run_frame("p16f11", 16, 11, 177, 1);

    // Config change while enabled is ignored; drop enable mid-bit, then 32x takes effect.
    idle_load(PRESC_8, 10);
    prescale = PW'(PRESC_32);
    run_frame("p8hold", 8, 10, 21, 0);
    enable = 1'b0;
    #1;
    check_eq("drop edge held", 32'(edge_cnt), 5);
    check_eq("drop strobes", {29'd0, sample_stb, bit_done, frame_done}, 0);
    step();
    check_eq("drop edge clr", 32'(edge_cnt), 0);
    check_eq("drop bit clr", 32'(bit_cnt), 0);
    enable = 1'b1;
    run_frame("p32", 32, 10, 70, 0);

    // Sanitising of illegal configuration.
    idle_load(3, 1);
    run_frame("p3f1", 4, 2, 17, 2);
    idle_load(9, 10);
    run_frame("p9", 8, 10, 20, 0);
    idle_load(0, 0);
    run_frame("p0f0", 4, 2, 8, 1);

    // Enable dropped in the centre-sample cycle: strobes stop, counters clear.
    idle_load(PRESC_8, 10);
    run_frame("p8c", 8, 10, 3, 0);
    check_eq("centre stb", 32'(sample_stb), 1);
`ifdef RX_TRIPLE_SAMPLE_EN
    check_eq("centre idx", 32'(sample_idx), 1);
`endif
    enable = 1'b0;
    #1;
    check_eq("centre stb off", 32'(sample_stb), 0);
    step();
    check_eq("centre edge clr", 32'(edge_cnt), 0);
    check_eq("centre strobes", {29'd0, cur_idx(), sample_stb, bit_done, frame_done}, 0);

    // Async reset mid-count (edge 5, bit 3); reset config is 8x/10 even with other inputs.
    idle_load(PRESC_8, 10);
    run_frame("p8pre", 8, 10, 29, 0);
    check_eq("pre-rst edge", 32'(edge_cnt), 5);
    check_eq("pre-rst bit", 32'(bit_cnt), 3);
    prescale   = PW'(PRESC_32);
    frame_bits = BW'(3);
    rst        = 1'b0;
    #1;
    check_eq("arst edge", 32'(edge_cnt), 0);
    check_eq("arst bit", 32'(bit_cnt), 0);
    check_eq("arst strobes", {29'd0, sample_stb, bit_done, frame_done}, 0);
    step();
    rst = 1'b1;
    run_frame("postrst", 8, 10, 20, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
